alu_seq16: RTL

Multi-cycle 16-bit ALU built on a 4-bit nibble slice. It sits on the consumer side of the 4-bit ALU flag interface (R, CF, ZF, SF) and sequences operands through the slice one nibble per cycle, chaining carry and accumulating zero. Commands enter and results leave over independent valid/ready handshakes, so the block can hang off any register-file or command source in the design.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_nibble.sv | 29 ++
 rtl/alu_seq16.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU: slice width, op codes and
// sequencer states.
package alu_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_AND = 2'b01,
    ALU_OR  = 2'b10,
    ALU_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_nibble.sv
// Combinational 4-bit ALU slice: one nibble of ADD/SUB/AND/OR with carry in/out.
module alu_nibble
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  alu_op_e          op,
  input  logic             cin,
  output logic [NIB_W-1:0] r,
  output logic             cout
);

  logic [NIB_W:0] w_sum;

  always_comb begin
    w_sum = '0;
    case (op)
      ALU_ADD: w_sum = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
      // SUB is A + ~B + cin; the sequencer seeds cin=1 on the first nibble
      ALU_SUB: w_sum = {1'b0, a} + {1'b0, ~b} + {{NIB_W{1'b0}}, cin};
      ALU_AND: w_sum = {1'b0, a & b};
      ALU_OR:  w_sum = {1'b0, a | b};
      default: w_sum = '0;
    endcase
    r    = w_sum[NIB_W-1:0];
    cout = w_sum[NIB_W];
  end

endmodule

// File: rtl/alu_seq16.sv
// Multi-cycle ALU: feeds operands through alu_nibble LSB first, chaining carry
// and accumulating the zero flag, with valid/ready on command and result sides.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for a command
// ST_EXEC | one nibble processed per cycle, nibble r_nib_cnt
// ST_DONE | out_valid=1, result and flags held until out_ready
module alu_seq16
  import alu_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIB_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic         out_cf,
  output logic         out_zf,
  output logic         out_sf
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e           r_state, w_state_nxt;
  logic [W-1:0]     r_a, r_b, r_res;
  alu_op_e          r_op;
  logic [CW-1:0]    r_nib_cnt;
  logic             r_carry, r_zacc;
  logic [NIB_W-1:0] w_a_n, w_b_n, w_r;
  logic             w_cout, w_last;

  always_comb begin
    w_a_n = '0;
    w_b_n = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_nib_cnt == CW'(i)) begin
        w_a_n = r_a[NIB_W*i +: NIB_W];
        w_b_n = r_b[NIB_W*i +: NIB_W];
      end
    end
  end

  assign w_last = (r_nib_cnt == CW'(NIBBLES - 1));

  alu_nibble u_nib (
    .a    (w_a_n),
    .b    (w_b_n),
    .op   (r_op),
    .cin  (r_carry),
    .r    (w_r),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= ALU_ADD;
      r_nib_cnt <= '0;
      r_carry   <= 1'b0;
      r_zacc    <= 1'b0;
      r_res     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a       <= in_a;
            r_b       <= in_b;
            r_op      <= alu_op_e'(in_op);
            r_nib_cnt <= '0;
            r_carry   <= (alu_op_e'(in_op) == ALU_SUB);
            r_zacc    <= 1'b1;
          end
        end
        ST_EXEC: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (r_nib_cnt == CW'(i)) r_res[NIB_W*i +: NIB_W] <= w_r;
          end
          r_carry   <= w_cout;
          r_zacc    <= r_zacc & (w_r == '0);
          r_nib_cnt <= w_last ? '0 : r_nib_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_r  = r_res;
  assign out_cf = r_carry;
  assign out_zf = r_zacc;
  assign out_sf = r_res[W-1];

endmodule
